// File: rtl/spi_master_ctrl_pkg.sv
// Shared definitions for the SPI master controller: command codes, byte width and FSM encoding.
package spi_master_ctrl_pkg;

    localparam int SPI_BYTE_W = 8;

    localparam logic [SPI_BYTE_W-1:0] CMD_WRITE = 8'h02;
    localparam logic [SPI_BYTE_W-1:0] CMD_READ  = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_LOAD,
        ST_TRAIL,
        ST_GAP
    } spi_state_e;

endpackage

// File: rtl/spi_master_ctrl_sck_gen.sv
// SCK generator: divides clk by 2*CLK_DIV, flags the cycle on which SCK will rise or fall;
// hold parks SCK low and restarts the half-period count.
module spi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] div_cnt;
    logic          half_done;

    assign half_done = !hold && (div_cnt == CW'(CLK_DIV - 1));
    assign rise      = half_done && !sck;
    assign fall      = half_done && sck;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (hold) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (half_done) begin
            div_cnt <= '0;
            sck     <= !sck;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master issuing cmd/addr/data frames. Build option SPI_MISO_LATE_SAMPLE_EN moves
// the MISO sample point from the SCK rising edge to the following falling edge.
module spi_master_ctrl
    import spi_master_ctrl_pkg::*;
#(
    parameter int WIDTH   = SPI_BYTE_W,
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 4,
    parameter int CSN_GAP = 4
) (
    input  logic             sys_clk,
    input  logic             sys_reset,
    input  logic             start,
    input  logic [WIDTH-1:0] cmd,
    input  logic [WIDTH-1:0] addr,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             spi_clock,
    output logic             csn,
    output logic             MOSI,
    input  logic             MISO
);

    localparam int BIT_W  = $clog2(WIDTH);
    localparam int IDX_W  = LEN_W + 1;
    localparam int WAIT_W = $clog2(CLK_DIV + CSN_GAP + 1);

`ifdef SPI_MISO_LATE_SAMPLE_EN
    localparam bit LATE_SAMPLE = 1'b1;
`else
    localparam bit LATE_SAMPLE = 1'b0;
`endif

    spi_state_e        state, state_d;
    logic              is_read_q;
    logic [WIDTH-1:0]  addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [WIDTH-1:0]  tx_sr;
    logic [WIDTH-2:0]  rx_sr;
    logic [BIT_W-1:0]  bit_cnt;
    logic [IDX_W-1:0]  byte_idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_lim;
    logic              sck_rise, sck_fall, miso_sample;
    logic              last_bit, byte_end, last_byte, data_phase, load_go, wait_hit;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk   (sys_clk),
        .rst_n (sys_reset),
        .hold  (state != ST_SHIFT),
        .sck   (spi_clock),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    assign miso_sample = LATE_SAMPLE ? sck_fall : sck_rise;
    assign last_bit    = (bit_cnt == BIT_W'(WIDTH - 1));
    assign byte_end    = sck_fall && last_bit;
    assign last_byte   = (byte_idx == IDX_W'(len_q) + IDX_W'(1));
    assign data_phase  = (byte_idx >= IDX_W'(2));
    assign wait_lim    = (state == ST_GAP) ? WAIT_W'(CSN_GAP - 1) : WAIT_W'(CLK_DIV - 1);
    assign wait_hit    = (wait_cnt == wait_lim);

    // Only write frames stall for data; cmd/addr and read-frame bytes load unconditionally.
    assign tx_ready  = (state == ST_LOAD) && data_phase && !is_read_q;
    assign load_go   = (state == ST_LOAD) && (!tx_ready || tx_valid);
    assign busy      = (state != ST_IDLE);
    assign csn       = (state == ST_IDLE) || (state == ST_GAP);
    assign MOSI      = tx_sr[WIDTH-1];

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) state <= ST_IDLE;
        else            state <= state_d;
    end

    always_comb begin
        // NOTE: next state defaults to the current state first so no latch is inferred.
        state_d = state;
        case (state)
            ST_IDLE:  if (start)    state_d = ST_LEAD;
            ST_LEAD:  if (wait_hit) state_d = ST_SHIFT;
            ST_SHIFT: if (byte_end) state_d = last_byte ? ST_TRAIL : ST_LOAD;
            ST_LOAD:  if (load_go)  state_d = ST_SHIFT;
            ST_TRAIL: if (wait_hit) state_d = ST_GAP;
            ST_GAP:   if (wait_hit) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            is_read_q <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            done      <= 1'b0;
            bit_cnt   <= '0;
            byte_idx  <= '0;
            wait_cnt  <= '0;
        end else begin
            rx_valid <= 1'b0;
            done     <= 1'b0;

            if ((state == ST_LEAD || state == ST_TRAIL || state == ST_GAP) && state_d == state)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        is_read_q <= (cmd == WIDTH'(CMD_READ));
                        addr_q    <= addr;
                        len_q     <= len;
                        tx_sr     <= cmd;
                        bit_cnt   <= '0;
                        byte_idx  <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (miso_sample) begin
                        rx_sr <= {rx_sr[WIDTH-3:0], MISO};
                        if (last_bit && is_read_q && data_phase) begin
                            rx_data  <= {rx_sr, MISO};
                            rx_valid <= 1'b1;
                        end
                    end
                    // Shifting zeros in leaves MOSI low once a byte is fully sent.
                    if (sck_fall) begin
                        tx_sr   <= {tx_sr[WIDTH-2:0], 1'b0};
                        bit_cnt <= last_bit ? '0 : bit_cnt + BIT_W'(1);
                        if (last_bit) byte_idx <= byte_idx + IDX_W'(1);
                    end
                end
                ST_LOAD: begin
                    if (load_go) begin
                        if (byte_idx == IDX_W'(1)) tx_sr <= addr_q;
                        else if (is_read_q)        tx_sr <= '0;
                        else                       tx_sr <= tx_data;
                    end
                end
                ST_TRAIL: begin
                    if (wait_hit) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
